dsp_reset_sequencer: RTL and testbench

// - Drives the C6678 DSP reset pins (POR#, RESETFULL#, RESET#) in their required power-on / full / warm order.
// - Accepts reset requests from the board push-button (full) and an FPGA register (warm).
// - Sits downstream of the FPGA internal reset; runs a complete power-on sequence automatically when rst_n releases.
// - Waits for DSP RESETSTAT# to report completion, then flags done or timeout to the register block.

---
 rtl/dsp_reset_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_dsp_reset_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_reset_sequencer.sv
// C6678 reset-pin sequencer: drives POR#, RESETFULL#, RESET# in power-on / full / warm order.
// Define RSTSTAT_TIMEOUT_EN to bound the RESETSTAT# wait and make rst_timeout functional.
module dsp_reset_sequencer #(
  parameter int unsigned      CNT_W         = 16,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYC  = 16'd1000,
  parameter logic [CNT_W-1:0] POR_HOLD_CYC  = 16'd2000,
  parameter logic [CNT_W-1:0] FULL_HOLD_CYC = 16'd1000,
  parameter logic [CNT_W-1:0] WARM_HOLD_CYC = 16'd500,
  parameter logic [CNT_W-1:0] STAT_TMO_CYC  = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       full_rst_req_n,
  input  logic       warm_rst_req,
  input  logic       dsp_resetstat_n,
  output logic       dsp_por_n,
  output logic       dsp_resetfull_n,
  output logic       dsp_reset_n,
  output logic       rst_busy,
  output logic       rst_done,
  output logic       rst_timeout,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_POR_ASSERT  = 3'd1,
    ST_FULL_ASSERT = 3'd2,
    ST_WARM_ASSERT = 3'd3,
    ST_WAIT_STAT   = 3'd4
  } state_t;

`ifdef RSTSTAT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // Terminal counts: the counter starts at 0 on state entry, so N cycles end at N-1.
  localparam logic [CNT_W-1:0] DEB_LAST  = DEBOUNCE_CYC  - CNT_W'(1);
  localparam logic [CNT_W-1:0] POR_LAST  = POR_HOLD_CYC  - CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_LAST = FULL_HOLD_CYC - CNT_W'(1);
  localparam logic [CNT_W-1:0] WARM_LAST = WARM_HOLD_CYC - CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_LAST  = STAT_TMO_CYC  - CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;

  logic [1:0]       btn_sync;
  logic [1:0]       stat_sync;
  logic             btn_s;
  logic             stat_s;

  logic [CNT_W-1:0] deb_cnt;
  logic             deb_armed;
  logic             full_req;

  logic             por_next;
  logic             resetfull_next;
  logic             reset_next;
  logic             busy_next;
  logic             done_next;
  logic             tmo_set;
  logic             tmo_clr;
  logic             tmo_q;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync  <= 2'b11;
      stat_sync <= 2'b00;
    end else begin
      btn_sync  <= {btn_sync[0], full_rst_req_n};
      stat_sync <= {stat_sync[0], dsp_resetstat_n};
    end
  end

  assign btn_s  = btn_sync[1];
  assign stat_s = stat_sync[1];

  // One request per press: accepting disarms until the button is seen released.
  assign full_req = deb_armed && !btn_s && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      deb_armed <= 1'b0;
    end else if (btn_s) begin
      deb_cnt   <= '0;
      deb_armed <= 1'b1;
    end else if (full_req) begin
      deb_cnt   <= '0;
      deb_armed <= 1'b0;
    end else if (deb_armed) begin
      deb_cnt   <= deb_cnt + CNT_W'(1);
    end
  end

  // warm_rst_req is a fire-and-forget pulse with no ready: it is taken only in IDLE
  // when no full request is present that cycle, and silently dropped otherwise.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    tmo_set    = 1'b0;
    tmo_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (full_req) begin
          state_next = ST_POR_ASSERT;
          tmo_clr    = 1'b1;
        end else if (warm_rst_req) begin
          state_next = ST_WARM_ASSERT;
          tmo_clr    = 1'b1;
        end
      end
      ST_POR_ASSERT: begin
        if (cnt == POR_LAST) state_next = ST_FULL_ASSERT;
      end
      ST_FULL_ASSERT: begin
        if (cnt == FULL_LAST) state_next = ST_WAIT_STAT;
      end
      ST_WARM_ASSERT: begin
        if (full_req) begin
          state_next = ST_POR_ASSERT;
          tmo_clr    = 1'b1;
        end else if (cnt == WARM_LAST) begin
          state_next = ST_WAIT_STAT;
        end
      end
      ST_WAIT_STAT: begin
        if (full_req) begin
          state_next = ST_POR_ASSERT;
          tmo_clr    = 1'b1;
        end else if (stat_s) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else if (TMO_EN && (cnt == TMO_LAST)) begin
          state_next = ST_IDLE;
          tmo_set    = 1'b1;
        end
      end
      default: state_next = ST_POR_ASSERT;
    endcase

    cnt_clr = (state_next != state);

    // Pins are decoded from the next state so they change on the transition edge.
    por_next       = 1'b0;
    resetfull_next = 1'b0;
    reset_next     = 1'b0;
    busy_next      = 1'b1;
    case (state_next)
      ST_IDLE: begin
        por_next       = 1'b1;
        resetfull_next = 1'b1;
        reset_next     = 1'b1;
        busy_next      = 1'b0;
      end
      ST_FULL_ASSERT: begin
        por_next       = 1'b1;
      end
      ST_WARM_ASSERT: begin
        por_next       = 1'b1;
        resetfull_next = 1'b1;
      end
      ST_WAIT_STAT: begin
        por_next       = 1'b1;
        resetfull_next = 1'b1;
        reset_next     = 1'b1;
      end
      default: begin
        por_next       = 1'b0;
        resetfull_next = 1'b0;
        reset_next     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_POR_ASSERT;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_por_n       <= 1'b0;
      dsp_resetfull_n <= 1'b0;
      dsp_reset_n     <= 1'b0;
      rst_busy        <= 1'b1;
      rst_done        <= 1'b0;
    end else begin
      dsp_por_n       <= por_next;
      dsp_resetfull_n <= resetfull_next;
      dsp_reset_n     <= reset_next;
      rst_busy        <= busy_next;
      rst_done        <= done_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= 1'b0;
    end else if (tmo_clr) begin
      tmo_q <= 1'b0;
    end else if (tmo_set) begin
      tmo_q <= 1'b1;
    end
  end

  assign rst_timeout = TMO_EN ? tmo_q : 1'b0;

endmodule

// File: tb/tb_dsp_reset_sequencer.sv
// Bench for dsp_reset_sequencer: random reset requests, per-sequence records checked
// against a pulse-width reference model through an expected queue.
module tb_dsp_reset_sequencer;

  localparam int DEB    = 4;
  localparam int POR_H  = 8;
  localparam int FULL_H = 6;
  localparam int WARM_H = 5;
  localparam int TMO    = 20;
  localparam int REC_W  = 48;
  localparam logic [15:0] WAIT_DC = 16'hFFFF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       full_rst_req_n = 1'b1;
  logic       warm_rst_req = 1'b0;
  logic       dsp_resetstat_n = 1'b0;
  logic       dsp_por_n;
  logic       dsp_resetfull_n;
  logic       dsp_reset_n;
  logic       rst_busy;
  logic       rst_done;
  logic       rst_timeout;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [REC_W-1:0] exp_q[$];

  bit dsp_model_en = 1'b1;
  int dsp_delay = 3;

  dsp_reset_sequencer #(
    .CNT_W(16),
    .DEBOUNCE_CYC(16'd4),
    .POR_HOLD_CYC(16'd8),
    .FULL_HOLD_CYC(16'd6),
    .WARM_HOLD_CYC(16'd5),
    .STAT_TMO_CYC(16'd20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .full_rst_req_n(full_rst_req_n),
    .warm_rst_req(warm_rst_req),
    .dsp_resetstat_n(dsp_resetstat_n),
    .dsp_por_n(dsp_por_n),
    .dsp_resetfull_n(dsp_resetfull_n),
    .dsp_reset_n(dsp_reset_n),
    .rst_busy(rst_busy),
    .rst_done(rst_done),
    .rst_timeout(rst_timeout),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // DSP model: RESETSTAT# low while RESET# is low, high dsp_delay cycles after release.
  initial begin : dsp_model
    int hi_cnt;
    hi_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!dsp_reset_n) begin
        dsp_resetstat_n = 1'b0;
        hi_cnt = 0;
      end else if (dsp_model_en && !dsp_resetstat_n) begin
        if (hi_cnt >= dsp_delay) dsp_resetstat_n = 1'b1;
        else hi_cnt++;
      end
    end
  end

  // Record layout: order_ok, tmo_first, tmo_end, done count, wait cycles, RESET#/RESETFULL#/POR# low cycles.
  function automatic logic [REC_W-1:0] rec(input int por, input int full, input int rst,
                                           input logic [15:0] wt, input int done,
                                           input bit tmo_end, input bit tmo_first, input bit order_ok);
    return {1'b0, order_ok, tmo_first, tmo_end, 4'(done), wt, 8'(rst), 8'(full), 8'(por)};
  endfunction

  // RESETSTAT# crosses a 2-flop synchronizer and the FSM reacts one cycle later.
  function automatic logic [15:0] stat_wait(input int d);
    return 16'(d + 3);
  endfunction

  // Full sequence, optionally preceded by warm_cyc cycles of an aborted warm sequence.
  function automatic logic [REC_W-1:0] exp_full(input int warm_cyc, input logic [15:0] wt);
    return rec(POR_H, POR_H + FULL_H, POR_H + FULL_H + warm_cyc, wt, 1, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic logic [REC_W-1:0] exp_warm(input logic [15:0] wt, input bit timed_out);
    return rec(0, 0, WARM_H, wt, timed_out ? 0 : 1, timed_out, 1'b0, 1'b1);
  endfunction

  // scoreboard monitor: one record per busy period, compared at its end
  initial begin : monitor
    bit in_seq;
    bit order_ok;
    bit tmo_first;
    int por_c, full_c, rst_c, wait_c, done_c;
    logic [REC_W-1:0] got, exp;
    in_seq = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_seq = 1'b0;
      end else if (rst_busy || in_seq) begin
        if (!in_seq) begin
          in_seq = 1'b1;
          por_c = 0; full_c = 0; rst_c = 0; wait_c = 0; done_c = 0;
          order_ok = 1'b1;
          tmo_first = rst_timeout;
        end
        por_c  += int'(!dsp_por_n);
        full_c += int'(!dsp_resetfull_n);
        rst_c  += int'(!dsp_reset_n);
        wait_c += int'(rst_busy && dsp_por_n && dsp_resetfull_n && dsp_reset_n);
        done_c += int'(rst_done);
        if (!dsp_por_n && (dsp_resetfull_n || dsp_reset_n)) order_ok = 1'b0;
        if (!dsp_resetfull_n && dsp_reset_n) order_ok = 1'b0;
        if (!rst_busy) begin
          got = rec(por_c, full_c, rst_c, 16'(wait_c), done_c, rst_timeout, tmo_first, order_ok);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL seq_unexpected got=%h required=none", got);
          end else begin
            exp = exp_q.pop_front();
            if (exp[39:24] == WAIT_DC) got[39:24] = WAIT_DC;
            if (got !== exp) begin
              errors++;
              $display("FAIL seq_record got=%h required=%h", got, exp);
            end
          end
          in_seq = 1'b0;
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic wait_busy(input int max_cyc);
    int n = 0;
    while (!rst_busy && n < max_cyc) begin tick(1); n++; end
    if (!rst_busy) begin
      checks++; errors++;
      $display("FAIL wait_busy got=idle after %0d cycles required=busy", max_cyc);
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (rst_busy && n < max_cyc) begin tick(1); n++; end
    if (rst_busy) begin
      checks++; errors++;
      $display("FAIL wait_idle got=busy after %0d cycles required=idle", max_cyc);
    end
  endtask

  task automatic warm_pulse();
    warm_rst_req = 1'b1;
    tick(1);
    warm_rst_req = 1'b0;
  endtask

  // Button accepted k cycles after the warm request is taken (k=0: same IDLE cycle).
  task automatic combo(input int k, input int d);
    dsp_delay = d;
    exp_q.push_back(exp_full(k, stat_wait(d)));
    full_rst_req_n = 1'b0;
    tick(DEB + 1 - k);
    warm_pulse();
    tick(k + 2);
    full_rst_req_n = 1'b1;
    wait_busy(20);
    wait_idle(300);
    tick(4);
  endtask

  // stimulus
  initial begin : stimulus
    int lat, d, k, g, h;
    tick(3);
    check("reset_pins", {dsp_por_n, dsp_resetfull_n, dsp_reset_n}, 3'b000);
    check("reset_busy", rst_busy, 1'b1);
    check("reset_done", rst_done, 1'b0);
    check("reset_timeout", rst_timeout, 1'b0);

    // power-on sequence on rst_n release
    dsp_delay = 3;
    exp_q.push_back(exp_full(0, stat_wait(3)));
    rst_n = 1'b1;
    wait_idle(200);
    tick(4);
    check("poweron_idle_pins", {dsp_por_n, dsp_resetfull_n, dsp_reset_n}, 3'b111);

    // debounce: 3-cycle glitch, 1 high, then held low 54
    exp_q.push_back(exp_full(0, stat_wait(3)));
    full_rst_req_n = 1'b0; tick(3);
    full_rst_req_n = 1'b1; tick(1);
    full_rst_req_n = 1'b0;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (rst_busy) begin lat = i; break; end
    end
    check("debounce_latency", lat, 2 + DEB);
    tick(54 - lat);
    full_rst_req_n = 1'b1;
    wait_idle(200);
    tick(4);

    // warm
    dsp_delay = 2;
    exp_q.push_back(exp_warm(stat_wait(2), 1'b0));
    warm_pulse();
    check("warm_first_pins", {dsp_por_n, dsp_resetfull_n, dsp_reset_n}, 3'b110);
    wait_idle(200);
    tick(4);

    // full and warm in the same IDLE cycle, then preempt during WARM_ASSERT
    combo(0, 1);
    combo(3, 4);

`ifdef RSTSTAT_TIMEOUT_EN
    dsp_model_en = 1'b0;
    exp_q.push_back(exp_warm(16'(TMO), 1'b1));
    warm_pulse();
    wait_idle(200);
    tick(3);
    check("timeout_sticky", rst_timeout, 1'b1);
    dsp_model_en = 1'b1;
    dsp_delay = 2;
    exp_q.push_back(exp_warm(stat_wait(2), 1'b0));
    warm_pulse();
    check("timeout_cleared", rst_timeout, 1'b0);
    wait_idle(200);
    tick(4);
`else
    dsp_model_en = 1'b0;
    dsp_delay = 2;
    exp_q.push_back(exp_full(WARM_H, WAIT_DC));
    warm_pulse();
    tick(WARM_H + 100);
    check("wait_indefinite_busy", rst_busy, 1'b1);
    full_rst_req_n = 1'b0;
    for (int i = 0; i < 30 && dsp_por_n; i++) tick(1);
    check("wait_abort_por", dsp_por_n, 1'b0);
    dsp_model_en = 1'b1;
    tick(2);
    full_rst_req_n = 1'b1;
    wait_idle(200);
    tick(4);
    check("timeout_tied", rst_timeout, 1'b0);
`endif

    // rst_n pulsed during FULL_ASSERT
    dsp_delay = 1;
    full_rst_req_n = 1'b0;
    for (int i = 0; i < 60 && !(dsp_por_n && !dsp_resetfull_n); i++) tick(1);
    tick(2);
    rst_n = 1'b0;
    #1;
    check("midrst_pins", {dsp_por_n, dsp_resetfull_n, dsp_reset_n}, 3'b000);
    check("midrst_busy", rst_busy, 1'b1);
    full_rst_req_n = 1'b1;
    tick(3);
    exp_q.push_back(exp_full(0, stat_wait(1)));
    rst_n = 1'b1;
    wait_idle(200);
    tick(4);

    // randomized mix
    for (int it = 0; it < 16; it++) begin
      d = $urandom_range(0, 6);
      dsp_delay = d;
      case ($urandom_range(0, 2))
        0: begin
          exp_q.push_back(exp_warm(stat_wait(d), 1'b0));
          warm_pulse();
          wait_idle(300);
        end
        1: begin
          g = $urandom_range(0, DEB - 1);
          if (g > 0) begin
            full_rst_req_n = 1'b0; tick(g);
            full_rst_req_n = 1'b1; tick($urandom_range(1, 3));
          end
          exp_q.push_back(exp_full(0, stat_wait(d)));
          h = DEB + $urandom_range(0, 10);
          full_rst_req_n = 1'b0; tick(h);
          full_rst_req_n = 1'b1;
          if (rst_busy && ($urandom_range(0, 1) == 1)) warm_pulse();
          wait_busy(20);
          wait_idle(300);
        end
        default: begin
          k = $urandom_range(0, 5);
          combo(k, d);
        end
      endcase
      tick($urandom_range(4, 8));
    end

    tick(10);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
